// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage with a 2^LOG2_DEPTH delay line,
// an elaboration-time twiddle ROM, forward/inverse twiddles and automatic end-of-stream drain.
module r2sdf_stage #(
    parameter int unsigned IN_W       = 36,
    parameter int unsigned LOG2_DEPTH = 1,
    parameter int unsigned TW_W       = 18
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iData_valid,
    input  logic signed [IN_W-1:0] iData_Re,
    input  logic signed [IN_W-1:0] iData_Im,
    input  logic                   iInverse,
    output logic                   oReady,
    output logic                   oData_valid,
    output logic signed [IN_W:0]   oData_Re,
    output logic signed [IN_W:0]   oData_Im
);

    localparam int unsigned OW    = IN_W + 1;
    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned CW    = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int unsigned PW    = OW + TW_W + 1;

    localparam logic [CW-1:0]        J_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0]        J_HALF = CW'(DEPTH / 2);
    localparam logic signed [PW-1:0] P_MAX  = PW'({1'b0, {(OW-1){1'b1}}});
    localparam logic signed [PW-1:0] P_MIN  = ~P_MAX;
    localparam logic signed [PW-1:0] P_RND  = PW'(1) << (TW_W - 2);
    localparam real                  P_PI   = 3.14159265358979323846;
    localparam real                  P_SCALE = real'((longint'(1) << (TW_W - 1)) - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BFLY, S_DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_j, w_j_nxt, w_j_inc;
    logic                   r_pend, w_pend_nxt;
    logic                   r_inv_blk, r_inv_pend;
    logic                   r_ready;
    logic                   r_out_valid;
    logic signed [OW-1:0]   r_out_re, r_out_im;
    logic signed [OW-1:0]   r_buf_re [DEPTH];
    logic signed [OW-1:0]   r_buf_im [DEPTH];

    logic                   w_last;
    logic                   w_buf_we, w_buf_wdiff, w_out_en, w_out_sum;
    logic                   w_inv_latch, w_inv_hand;
    logic signed [OW-1:0]   w_x_re, w_x_im, w_b_re, w_b_im;
    logic signed [OW-1:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [OW-1:0]   w_tw_re, w_tw_im;
    logic signed [TW_W-1:0] w_rom_cos [DEPTH];
    logic signed [TW_W-1:0] w_rom_sin [DEPTH];
    logic signed [TW_W-1:0] w_c, w_s;
    logic signed [PW-1:0]   w_ac, w_bs, w_bc, w_as;
    logic signed [PW-1:0]   w_pr_re, w_pr_im, w_sh_re, w_sh_im;

    // cos/sin of pi*k/DEPTH scaled to TW_W-1 fractional bits, rounded at elaboration
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam real ANG = P_PI * real'(k) / real'(DEPTH);
        localparam int  C_I = int'($cos(ANG) * P_SCALE);
        localparam int  S_I = int'($sin(ANG) * P_SCALE);
        assign w_rom_cos[k] = TW_W'(C_I);
        assign w_rom_sin[k] = TW_W'(S_I);
    end

    function automatic logic signed [OW-1:0] f_sat(input logic signed [PW-1:0] v);
        if (v > P_MAX)      return OW'(P_MAX);
        else if (v < P_MIN) return OW'(P_MIN);
        else                return OW'(v);
    endfunction

    assign w_x_re   = {iData_Re[IN_W-1], iData_Re};
    assign w_x_im   = {iData_Im[IN_W-1], iData_Im};
    assign w_b_re   = r_buf_re[r_j];
    assign w_b_im   = r_buf_im[r_j];
    assign w_sum_re = w_b_re + w_x_re;
    assign w_sum_im = w_b_im + w_x_im;
    assign w_dif_re = w_b_re - w_x_re;
    assign w_dif_im = w_b_im - w_x_im;

    assign w_c     = w_rom_cos[r_j];
    assign w_s     = w_rom_sin[r_j];
    assign w_ac    = PW'(w_b_re) * PW'(w_c);
    assign w_bs    = PW'(w_b_im) * PW'(w_s);
    assign w_bc    = PW'(w_b_im) * PW'(w_c);
    assign w_as    = PW'(w_b_re) * PW'(w_s);
    assign w_pr_re = (r_inv_pend ? (w_ac - w_bs) : (w_ac + w_bs)) + P_RND;
    assign w_pr_im = (r_inv_pend ? (w_bc + w_as) : (w_bc - w_as)) + P_RND;
    assign w_sh_re = w_pr_re >>> (TW_W - 1);
    assign w_sh_im = w_pr_im >>> (TW_W - 1);

    // Twiddle of the pending difference at buffer[j]; j=0 and j=DEPTH/2 are exact
    always_comb begin
        w_tw_re = w_b_re;
        w_tw_im = w_b_im;
        if (r_j == '0) begin
            w_tw_re = w_b_re;
            w_tw_im = w_b_im;
        end else if (r_j == J_HALF) begin
            w_tw_re = r_inv_pend ? -w_b_im : w_b_im;
            w_tw_im = r_inv_pend ? w_b_re  : -w_b_re;
        end else begin
            w_tw_re = f_sat(w_sh_re);
            w_tw_im = f_sat(w_sh_im);
        end
    end

    assign w_last  = (r_j == J_LAST);
    assign w_j_inc = w_last ? '0 : r_j + CW'(1);

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_pend_nxt  = r_pend;
        w_buf_we    = 1'b0;
        w_buf_wdiff = 1'b0;
        w_out_en    = 1'b0;
        w_out_sum   = 1'b0;
        w_inv_latch = 1'b0;
        w_inv_hand  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iData_valid) begin
                    w_buf_we    = 1'b1;
                    w_inv_latch = 1'b1;
                    w_j_nxt     = w_j_inc;
                    w_state_nxt = w_last ? S_BFLY : S_FILL;
                end
            end
            S_FILL: begin
                if (iData_valid) begin
                    w_buf_we    = 1'b1;
                    w_out_en    = r_pend;
                    w_inv_latch = (r_j == '0);
                    w_j_nxt     = w_j_inc;
                    if (w_last) begin
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_BFLY;
                    end
                end else if ((r_j == '0) && r_pend) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_BFLY: begin
                if (iData_valid) begin
                    w_buf_we    = 1'b1;
                    w_buf_wdiff = 1'b1;
                    w_out_en    = 1'b1;
                    w_out_sum   = 1'b1;
                    w_j_nxt     = w_j_inc;
                    if (w_last) begin
                        w_pend_nxt  = 1'b1;
                        w_inv_hand  = 1'b1;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_DRAIN: begin
                w_out_en = 1'b1;
                w_j_nxt  = w_j_inc;
                if (w_last) begin
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state     <= S_IDLE;
            r_j         <= '0;
            r_pend      <= 1'b0;
            r_inv_blk   <= 1'b0;
            r_inv_pend  <= 1'b0;
            r_ready     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_j         <= w_j_nxt;
            r_pend      <= w_pend_nxt;
            r_ready     <= (w_state_nxt != S_DRAIN);
            r_out_valid <= w_out_en;
            if (w_inv_latch) r_inv_blk  <= iInverse;
            if (w_inv_hand)  r_inv_pend <= r_inv_blk;
            if (w_out_en) begin
                r_out_re <= w_out_sum ? w_sum_re : w_tw_re;
                r_out_im <= w_out_sum ? w_sum_im : w_tw_im;
            end
        end
    end

    // Delay line storage; contents survive reset
    always_ff @(posedge iClk) begin
        if (w_buf_we) begin
            r_buf_re[r_j] <= w_buf_wdiff ? w_dif_re : w_x_re;
            r_buf_im[r_j] <= w_buf_wdiff ? w_dif_im : w_x_im;
        end
    end

    assign oReady      = r_ready;
    assign oData_valid = r_out_valid;
    assign oData_Re    = r_out_re;
    assign oData_Im    = r_out_im;

endmodule

// File: tb/tb_r2sdf_stage.sv
// Bench for r2sdf_stage: three instances (DEPTH 2, DEPTH 4, DEPTH 4 with 8-bit input) checked
// against a block-level DIF model (sums, then twiddled differences, in stream order).
module tb_r2sdf_stage;

    typedef struct {
        longint re;
        longint im;
    } cplx_t;

    localparam real PI = 3.14159265358979323846;

    logic               clk;
    logic               rst_n;
    logic               v;
    logic               inv;
    logic signed [35:0] dre, dim;
    int                 sel;

    logic               a_rdy, a_ov, b_rdy, b_ov, c_rdy, c_ov;
    logic signed [36:0] a_re, a_im, b_re, b_im;
    logic signed [8:0]  c_re, c_im;

    logic               obs_valid, obs_rdy;
    longint             obs_re, obs_im;

    cplx_t  q[$];
    cplx_t  blk[$];
    cplx_t  seen[$];
    int     m_d, m_ow;
    bit     m_inv;
    int     n_cmp, n_err, rdy_low;
    bit     last_acc;
    longint cur_re, cur_im;

    r2sdf_stage #(.IN_W(36), .LOG2_DEPTH(1), .TW_W(18)) u_a (
        .iClk(clk), .iRst_n(rst_n), .iData_valid(v && sel == 0),
        .iData_Re(dre), .iData_Im(dim), .iInverse(inv),
        .oReady(a_rdy), .oData_valid(a_ov), .oData_Re(a_re), .oData_Im(a_im)
    );

    r2sdf_stage #(.IN_W(36), .LOG2_DEPTH(2), .TW_W(18)) u_b (
        .iClk(clk), .iRst_n(rst_n), .iData_valid(v && sel == 1),
        .iData_Re(dre), .iData_Im(dim), .iInverse(inv),
        .oReady(b_rdy), .oData_valid(b_ov), .oData_Re(b_re), .oData_Im(b_im)
    );

    r2sdf_stage #(.IN_W(8), .LOG2_DEPTH(2), .TW_W(18)) u_c (
        .iClk(clk), .iRst_n(rst_n), .iData_valid(v && sel == 2),
        .iData_Re(dre[7:0]), .iData_Im(dim[7:0]), .iInverse(inv),
        .oReady(c_rdy), .oData_valid(c_ov), .oData_Re(c_re), .oData_Im(c_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_valid = a_ov;
        obs_rdy   = a_rdy;
        obs_re    = longint'(a_re);
        obs_im    = longint'(a_im);
        if (sel == 1) begin
            obs_valid = b_ov;
            obs_rdy   = b_rdy;
            obs_re    = longint'(b_re);
            obs_im    = longint'(b_im);
        end else if (sel == 2) begin
            obs_valid = c_ov;
            obs_rdy   = c_rdy;
            obs_re    = longint'(c_re);
            obs_im    = longint'(c_im);
        end
    end

    function automatic cplx_t mk(longint re, longint im);
        cplx_t r;
        r.re = re;
        r.im = im;
        return r;
    endfunction

    function automatic cplx_t seen_at(int i);
        if (i < seen.size()) return seen[i];
        return mk(0, 0);
    endfunction

    function automatic longint rnd_real(real x);
        if (x >= 0.0) return longint'($floor(x + 0.5));
        return -longint'($floor(-x + 0.5));
    endfunction

    function automatic longint sat(longint x);
        longint mx;
        mx = (longint'(1) <<< (m_ow - 1)) - 1;
        if (x > mx) return mx;
        if (x < -mx - 1) return -mx - 1;
        return x;
    endfunction

    // Difference times W^k (or its conjugate): exact at k=0 and k=D/2, else rounded Q17 product
    function automatic cplx_t tw(longint a, longint b, int k);
        real    ang, sc;
        longint c, s, wi, pr, pim;
        if (k == 0) return mk(a, b);
        if (m_d >= 2 && k == m_d / 2) return m_inv ? mk(-b, a) : mk(b, -a);
        ang = PI * real'(k) / real'(m_d);
        sc  = 131071.0;
        c   = rnd_real($cos(ang) * sc);
        s   = rnd_real($sin(ang) * sc);
        wi  = m_inv ? s : -s;
        pr  = a * c - b * wi;
        pim = a * wi + b * c;
        return mk(sat((pr + 65536) >>> 17), sat((pim + 65536) >>> 17));
    endfunction

    task automatic model_accept(longint re, longint im, bit iv);
        int n;
        if (blk.size() == 0) m_inv = iv;
        blk.push_back(mk(re, im));
        n = blk.size();
        if (n > m_d) q.push_back(mk(blk[n-1-m_d].re + re, blk[n-1-m_d].im + im));
        if (n == 2 * m_d) begin
            for (int k = 0; k < m_d; k++)
                q.push_back(tw(blk[k].re - blk[k+m_d].re, blk[k].im - blk[k+m_d].im, k));
            blk.delete();
        end
    endtask

    task automatic chk(string tag, longint obs, longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(bit acc);
        cplx_t e;
        if (acc) chk("out_timing", longint'(obs_valid), longint'(q.size() != 0));
        else if (blk.size() != 0) chk("stall_quiet", longint'(obs_valid), 0);
        if (obs_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", longint'(q.size()), 1);
            end else begin
                e = q.pop_front();
                chk("out_re", obs_re, e.re);
                chk("out_im", obs_im, e.im);
            end
            seen.push_back(mk(obs_re, obs_im));
        end
    endtask

    task automatic tick();
        bit acc;
        acc = v && obs_rdy;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (!obs_rdy) rdy_low++;
        if (acc) model_accept(cur_re, cur_im, inv);
        check_out(acc);
    endtask

    task automatic send(longint re, longint im, bit iv);
        int t;
        cur_re = re;
        cur_im = im;
        dre    = 36'(re);
        dim    = 36'(im);
        inv    = iv;
        v      = 1'b1;
        t      = 0;
        do begin
            tick();
            t++;
        end while (!last_acc && t < 100);
        chk("accept_wait", longint'(last_acc), 1);
        v = 1'b0;
    endtask

    task automatic setup(int s, int d, int ow);
        sel  = s;
        m_d  = d;
        m_ow = ow;
        q.delete();
        blk.delete();
        seen.delete();
    endtask

    function automatic longint rnd_val();
        logic [63:0] r;
        int          sh;
        r  = {$urandom(), $urandom()};
        sh = 64 - (m_ow - 1);
        return $signed(r << sh) >>> sh;
    endfunction

    task automatic rand_run(int nblk);
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 2 * m_d; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
            end
        end
        repeat (2 * m_d + 4) tick();
        chk("rand_drained", longint'(q.size()), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        v     = 1'b0;
        inv   = 1'b0;
        dre   = '0;
        dim   = '0;
        n_cmp = 0;
        n_err = 0;
        rdy_low = 0;
        last_acc = 1'b0;
        cur_re = 0;
        cur_im = 0;
        m_inv = 1'b0;
        setup(0, 2, 37);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(obs_valid), 0);
        chk("rst_re", obs_re, 0);
        chk("rst_im", obs_im, 0);
        chk("rst_ready", longint'(obs_rdy), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while draining
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0); send(8, 0, 0);
        tick();
        tick();
        chk("pre_rst_valid", longint'(obs_valid), 1);
        chk("pre_rst_ready", longint'(obs_rdy), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(obs_valid), 0);
        chk("mid_rst_re", obs_re, 0);
        chk("mid_rst_im", obs_im, 0);
        chk("mid_rst_ready", longint'(obs_rdy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        setup(0, 2, 37);

        // DEPTH=2 forward block, then drain
        rdy_low = 0;
        send(10, 0, 0); send(20, 0, 0); send(1, 0, 0); send(2, 0, 0);
        chk("fwd_stream_ready_low", rdy_low, 0);
        rdy_low = 0;
        repeat (6) tick();
        chk("fwd_drain_ready_low", rdy_low, 2);
        chk("fwd_count", longint'(seen.size()), 4);
        chk("fwd_sum1_re", seen_at(1).re, 22);
        chk("fwd_d0_re", seen_at(2).re, 9);
        chk("fwd_d1_re", seen_at(3).re, 0);
        chk("fwd_d1_im", seen_at(3).im, -18);

        // Inverse block; iInverse toggled after the first sample must not matter
        setup(0, 2, 37);
        send(10, 0, 1); send(20, 0, 0); send(1, 0, 0); send(2, 0, 1);
        repeat (6) tick();
        chk("inv_d1_re", seen_at(3).re, 0);
        chk("inv_d1_im", seen_at(3).im, 18);

        // Back-to-back blocks: no drain in between
        setup(0, 2, 37);
        rdy_low = 0;
        send(10, 0, 0); send(20, 0, 0); send(1, 0, 0); send(2, 0, 0);
        send(30, 0, 0); send(40, 0, 0); send(7, 0, 0); send(8, 0, 0);
        chk("b2b_ready_low", rdy_low, 0);
        chk("b2b_d0_re", seen_at(2).re, 9);
        chk("b2b_d1_im", seen_at(3).im, -18);
        repeat (6) tick();
        chk("b2b_count", longint'(seen.size()), 8);

        rand_run(10);

        // DEPTH=4: twiddle at j=1 and a stall inside BFLY
        setup(1, 4, 37);
        send(0, 0, 0); send(1000, 0, 0); send(0, 0, 0); send(0, 0, 0);
        send(0, 0, 0); send(0, 0, 0);
        tick();
        send(0, 0, 0); send(0, 0, 0);
        repeat (10) tick();
        chk("d4_count", longint'(seen.size()), 8);
        chk("d4_tw1_re", seen_at(5).re, 707);
        chk("d4_tw1_im", seen_at(5).im, -707);
        rand_run(8);

        // DEPTH=4, 8-bit input: saturation at j=1
        setup(2, 4, 9);
        send(0, 0, 0); send(127, 127, 0); send(0, 0, 0); send(0, 0, 0);
        send(0, 0, 0); send(-128, -128, 0); send(0, 0, 0); send(0, 0, 0);
        repeat (10) tick();
        chk("sat_re", seen_at(5).re, 255);
        chk("sat_im", seen_at(5).im, 0);
        rand_run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
